// File: rtl/uart_rx_fifo_writer.sv
// 8N1 serial receiver feeding a byte FIFO write port.
// Oversamples rx through a two-flop synchronizer, deserializes LSB first, and
// issues a one-cycle write strobe per good frame. A frame that arrives while the
// FIFO is full is reported with overrun. A frame with a low stop bit is reported
// with frame_err.
module uart_rx_fifo_writer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             full,
    output logic             wr,
    output logic [WIDTH-1:0] data_out,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic             r_wr;
    logic             w_wr_next;
    logic             r_overrun;
    logic             w_overrun_next;
    logic             r_frame_err;
    logic             w_frame_err_next;
    logic             r_busy;

    // Two-flop synchronizer; presets to idle-high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, sample and output-pulse decode for the receive state machine.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_wr_next        = 1'b0;
        w_overrun_next   = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    // A line that is high again at mid-start was a glitch.
                    w_state_next = r_sync2 ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = r_sync2;
                    if (r_idx == IDX_LAST) begin
                        w_idx_next   = '0;
                        w_state_next = S_STOP;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_sync2) begin
                        w_state_next = S_IDLE;
                        // full only matters in this one cycle.
                        if (full) begin
                            w_overrun_next = 1'b1;
                        end else begin
                            w_wr_next   = 1'b1;
                            w_data_next = r_shift;
                        end
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = S_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it reports only one frame_err.
                if (r_sync2) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_wr        <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_wr        <= w_wr_next;
            r_overrun   <= w_overrun_next;
            r_frame_err <= w_frame_err_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    assign wr        = r_wr;
    assign data_out  = r_data;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Bench for uart_rx_fifo_writer: table of frames with hand-derived outcomes,
// directed corner sequences, and random traffic checked cycle by cycle against a
// sample-point model computed from the recorded line history.
module tb_uart_rx_fifo_writer;
    localparam int CPB  = 4;
    localparam int W    = 8;
    localparam int MAXC = 8000;
    localparam int FLEN = CPB * (W + 2);

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       full;
    logic       wr;
    logic [7:0] data_out;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    uart_rx_fifo_writer #(
        .CLKS_PER_BIT (CPB),
        .WIDTH        (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .full      (full),
        .wr        (wr),
        .data_out  (data_out),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs present at edge c, and outputs observed just after edge c.
    logic       rx_h   [MAXC];
    logic       full_h [MAXC];
    logic       rst_h  [MAXC];
    logic       wr_h   [MAXC];
    logic       ov_h   [MAXC];
    logic       fe_h   [MAXC];
    logic       busy_h [MAXC];
    logic [7:0] data_h [MAXC];
    // Model expectations.
    logic       e_wr   [MAXC];
    logic       e_ov   [MAXC];
    logic       e_fe   [MAXC];
    logic       e_busy [MAXC];
    logic [7:0] e_byte [MAXC];
    logic [7:0] e_data [MAXC];

    int cyc    = 0;
    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       full;
        int         gap;
        int         x_wr;
        logic [7:0] x_data;
        int         x_ov;
        int         x_fe;
    } vec_t;

    task automatic tick();
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rx_h[cyc]   = rx;
        full_h[cyc] = full;
        rst_h[cyc]  = reset;
        @(posedge clk);
        #1;
        wr_h[cyc]   = wr;
        ov_h[cyc]   = overrun;
        fe_h[cyc]   = frame_err;
        busy_h[cyc] = busy;
        data_h[cyc] = data_out;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full frame; rst_at >= 0 pulses reset at that cycle offset in the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at);
        int bi;
        for (int k = 0; k < FLEN; k++) begin
            bi = k / CPB;
            if (bi == 0) rx = 1'b0;
            else if (bi <= W) rx = b[bi-1];
            else rx = stop;
            reset = (k == rst_at);
            tick();
        end
        reset = 1'b0;
        rx    = 1'b1;
    endtask

    function automatic int count_ev(input int kind, input int a, input int b);
        int n = 0;
        for (int c = a; c < b; c++) begin
            if (kind == 0 && wr_h[c] === 1'b1) n++;
            if (kind == 1 && ov_h[c] === 1'b1) n++;
            if (kind == 2 && fe_h[c] === 1'b1) n++;
            if (kind == 3 && busy_h[c] === 1'b1) n++;
        end
        return n;
    endfunction

    // Synchronized line value the receiver acts on at edge n.
    function automatic logic vdec(input int n);
        int m = n - 1;
        if (m < 1) return 1'b1;
        if (rst_h[m] || rst_h[m-1]) return 1'b1;
        return rx_h[m-1];
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int c = a; c <= b && c < cyc; c++) begin
            if (rst_h[c]) return c;
        end
        return -1;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int c = a; c <= b && c < cyc; c++) e_busy[c] = 1'b1;
    endtask

    // Walks the recorded line: start edge, mid-start check, data and stop sample
    // points at fixed bit-period offsets, with reset aborting any frame.
    task automatic run_model();
        int n, e, s, p, b, r;
        logic [7:0] by;
        logic [7:0] cur;
        bit done;
        for (int c = 0; c < cyc; c++) begin
            e_wr[c]   = 1'b0;
            e_ov[c]   = 1'b0;
            e_fe[c]   = 1'b0;
            e_busy[c] = 1'b0;
            e_byte[c] = 8'h00;
        end
        n    = 0;
        done = 1'b0;
        while (!done && n < cyc) begin
            if (rst_h[n] || vdec(n)) begin
                n++;
            end else begin
                e = n;
                s = e + CPB / 2;
                r = first_rst(e, s);
                if (r >= 0) begin
                    mark_busy(e, r - 1);
                    n = r;
                end else if (s >= cyc) begin
                    mark_busy(e, cyc - 1);
                    done = 1'b1;
                end else if (vdec(s)) begin
                    mark_busy(e, s - 1);
                    n = s + 1;
                end else begin
                    p = s + CPB * (W + 1);
                    r = first_rst(s + 1, p);
                    if (r >= 0) begin
                        mark_busy(e, r - 1);
                        n = r;
                    end else if (p >= cyc) begin
                        mark_busy(e, cyc - 1);
                        done = 1'b1;
                    end else begin
                        for (int i = 0; i < W; i++) by[i] = vdec(s + CPB * (i + 1));
                        if (vdec(p)) begin
                            mark_busy(e, p - 1);
                            if (full_h[p]) begin
                                e_ov[p] = 1'b1;
                            end else begin
                                e_wr[p]   = 1'b1;
                                e_byte[p] = by;
                            end
                            n = p + 1;
                        end else begin
                            e_fe[p] = 1'b1;
                            b = p + 1;
                            while (b < cyc && !rst_h[b] && !vdec(b)) b++;
                            mark_busy(e, b - 1);
                            if (b >= cyc) done = 1'b1;
                            else if (rst_h[b]) n = b;
                            else n = b + 1;
                        end
                    end
                end
            end
        end
        cur = 8'h00;
        for (int c = 0; c < cyc; c++) begin
            if (rst_h[c]) cur = 8'h00;
            else if (e_wr[c]) cur = e_byte[c];
            e_data[c] = cur;
        end
    endtask

    initial begin
        vec_t vt[6];
        int   st[7];
        int   a, z, wc, g0, b0, rh, r0, rr, gap, rst_at;
        logic [11:0] act, exp;
        logic [7:0]  rb;
        logic        rs, rf;

        vt[0] = '{8'hA5, 1'b1, 1'b0, 2, 1, 8'hA5, 0, 0};
        vt[1] = '{8'h00, 1'b1, 1'b0, 0, 1, 8'h00, 0, 0};
        vt[2] = '{8'hFF, 1'b1, 1'b0, 3, 1, 8'hFF, 0, 0};
        vt[3] = '{8'h3C, 1'b1, 1'b1, 3, 0, 8'hFF, 1, 0};
        vt[4] = '{8'h12, 1'b0, 1'b0, 4, 0, 8'hFF, 0, 1};
        vt[5] = '{8'h81, 1'b1, 1'b0, 4, 1, 8'h81, 0, 0};

        reset = 1'b1;
        rx    = 1'b1;
        full  = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {wr_h[2], ov_h[2], fe_h[2], busy_h[2], data_h[2]}, 12'h000);
        reset = 1'b0;
        repeat (4) tick();

        // Table frames; 0x00 and 0xFF go back to back with no idle gap.
        for (int k = 0; k < 6; k++) begin
            st[k] = cyc;
            full  = vt[k].full;
            send_frame(vt[k].b, vt[k].stop, -1);
            repeat (vt[k].gap) tick();
        end
        full  = 1'b0;
        st[6] = cyc;
        for (int k = 0; k < 6; k++) begin
            a = st[k] + 1;
            z = (k == 5) ? cyc : st[k + 1] + 1;
            check($sformatf("vec%0d_wr", k), count_ev(0, a, z), vt[k].x_wr);
            check($sformatf("vec%0d_ov", k), count_ev(1, a, z), vt[k].x_ov);
            check($sformatf("vec%0d_fe", k), count_ev(2, a, z), vt[k].x_fe);
            check($sformatf("vec%0d_data", k), data_h[z - 1], vt[k].x_data);
            for (int c = a; c < z; c++) begin
                if (wr_h[c] === 1'b1) begin
                    check($sformatf("vec%0d_busy_fall", k), {busy_h[c - 1], busy_h[c]}, 2'b10);
                end
            end
        end

        // One-cycle low glitch aborts in START.
        rx = 1'b0;
        g0 = cyc;
        tick();
        rx = 1'b1;
        repeat (12) tick();
        wc = count_ev(3, g0, cyc);
        check("glitch_busy_seen", (wc > 0), 1);
        check("glitch_busy_bound", (wc <= CPB / 2 + 1), 1);
        check("glitch_no_pulses", count_ev(0, g0, cyc) + count_ev(1, g0, cyc) + count_ev(2, g0, cyc), 0);

        // Bad stop bit followed by a long break.
        b0 = cyc;
        send_frame(8'h55, 1'b0, -1);
        rx = 1'b0;
        repeat (40) tick();
        rx = 1'b1;
        rh = cyc;
        repeat (8) tick();
        check("break_one_fe", count_ev(2, b0, cyc), 1);
        check("break_no_wr", count_ev(0, b0, cyc), 0);
        check("break_busy_exit", {busy_h[rh + 1], busy_h[rh + 2]}, 2'b10);
        a = cyc;
        send_frame(8'h81, 1'b1, -1);
        repeat (4) tick();
        check("after_break_wr", count_ev(0, a, cyc), 1);
        check("after_break_data", data_h[cyc - 1], 8'h81);

        // Reset during data bit 3.
        r0 = cyc;
        send_frame(8'hFA, 1'b1, CPB * 4 + 1);
        rr = r0 + CPB * 4 + 1;
        repeat (4) tick();
        check("midreset_outputs", {wr_h[rr], ov_h[rr], fe_h[rr], busy_h[rr], data_h[rr]}, 12'h000);
        check("midreset_no_wr", count_ev(0, rr, cyc), 0);
        a = cyc;
        send_frame(8'h7E, 1'b1, -1);
        repeat (4) tick();
        check("after_reset_wr", count_ev(0, a, cyc), 1);
        check("after_reset_data", data_h[cyc - 1], 8'h7E);

        // Random traffic: bad stops, full, gaps, glitches and stray resets.
        for (int k = 0; k < 60; k++) begin
            rb     = 8'($urandom);
            rs     = ($urandom_range(0, 7) != 0);
            rf     = ($urandom_range(0, 3) == 0);
            gap    = $urandom_range(0, 6);
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, FLEN - 1) : -1;
            full   = rf;
            send_frame(rb, rs, rst_at);
            repeat (gap) tick();
            if ($urandom_range(0, 5) == 0) begin
                rx = 1'b0;
                tick();
                rx = 1'b1;
                repeat (3) tick();
            end
        end
        full = 1'b0;
        rx   = 1'b1;
        repeat (12) tick();

        run_model();
        for (int c = 0; c < cyc; c++) begin
            act = {wr_h[c], ov_h[c], fe_h[c], busy_h[c], data_h[c]};
            exp = {e_wr[c], e_ov[c], e_fe[c], e_busy[c], e_data[c]};
            checks++;
            if (act !== exp) begin
                errs++;
                $display("FAIL model_cycle%0d {wr,ov,fe,busy,data}: got %03h expected %03h",
                         c, act, exp);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
